// File: rtl/s2p_frame_rx.sv
// -----------------------------------------------------------------------------
// s2p_frame_rx
//   Serial-to-parallel frame receiver. Hunts for byte alignment on a stream of
//   COM idle bytes, locks after LOCK_CNT consecutive aligned COMs, and then
//   assembles 32-bit payload words that each follow an STP header byte.
//
// Ports
//   CLK      in   1   sole clock, all state on its rising edge
//   reset    in   1   asynchronous, active-low reset
//   ENB      in   1   enable; 0 freezes all state and ignores data_in
//   data_in  in   1   serial bit, MSB first within each byte
//   DATO     out  32  last received payload word, first byte in [31:24]
//   VALID    out  1   one-cycle pulse when DATO has just been updated
//   ACTIVE   out  1   high while byte-locked (LOCKED or DATA)
//   ERR      out  1   one-cycle pulse when lock is lost on an illegal header
// -----------------------------------------------------------------------------
module s2p_frame_rx #(
    parameter logic [7:0] COM      = 8'hBC,
    parameter logic [7:0] STP      = 8'h7C,
    parameter int         LOCK_CNT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ENB,
    input  logic        data_in,
    output logic [31:0] DATO,
    output logic        VALID,
    output logic        ACTIVE,
    output logic        ERR
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_DATA   = 2'd3;

    localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);

    logic [1:0]  r_state;
    // Only the seven most recent bits are ever needed: the eighth comes
    // straight from data_in when the byte is formed.
    logic [6:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_cnt;
    logic [2:0]  r_com_cnt;
    // First three payload bytes; the fourth joins them directly into DATO.
    logic [23:0] r_word;
    logic [31:0] r_dato;
    logic        r_valid;
    logic        r_active;
    logic        r_err;

    logic [7:0]  w_rx_byte;
    logic        w_byte_done;
    logic [2:0]  w_com_inc;
    logic [1:0]  w_state_nxt;
    logic [2:0]  w_bit_cnt_nxt;
    logic [1:0]  w_byte_cnt_nxt;
    logic [2:0]  w_com_cnt_nxt;
    logic [23:0] w_word_nxt;
    logic [31:0] w_dato_nxt;
    logic        w_valid_nxt;
    logic        w_err_nxt;
    logic        w_active_nxt;

    assign w_rx_byte   = {r_sr, data_in};
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_com_inc   = r_com_cnt + 3'd1;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
        w_byte_cnt_nxt = r_byte_cnt;
        w_com_cnt_nxt  = r_com_cnt;
        w_word_nxt     = r_word;
        w_dato_nxt     = r_dato;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_SEARCH: begin
                // Sliding-window hunt: a COM on any bit boundary sets the
                // byte phase, so the bit counter restarts from here.
                if (w_rx_byte == COM) begin
                    w_state_nxt   = S_SYNC;
                    w_bit_cnt_nxt = 3'd0;
                    w_com_cnt_nxt = 3'd1;
                end
            end

            S_SYNC: begin
                if (w_byte_done) begin
                    if (w_rx_byte == COM) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_com_inc == LOCK_N) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        // Alignment never confirmed, so this is not an error.
                        w_state_nxt   = S_SEARCH;
                        w_com_cnt_nxt = 3'd0;
                    end
                end
            end

            S_LOCKED: begin
                if (w_byte_done) begin
                    if (w_rx_byte == STP) begin
                        w_state_nxt    = S_DATA;
                        w_byte_cnt_nxt = 2'd0;
                    end else if (w_rx_byte != COM) begin
                        w_state_nxt   = S_SEARCH;
                        w_com_cnt_nxt = 3'd0;
                        w_err_nxt     = 1'b1;
                    end
                end
            end

            S_DATA: begin
                // COM and STP values are ordinary payload here.
                if (w_byte_done) begin
                    w_word_nxt     = {r_word[15:0], w_rx_byte};
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_dato_nxt  = {r_word, w_rx_byte};
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_LOCKED;
                    end
                end
            end

            default: begin
                w_state_nxt = S_SEARCH;
            end
        endcase

        w_active_nxt = (w_state_nxt == S_LOCKED) || (w_state_nxt == S_DATA);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= S_SEARCH;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_com_cnt  <= '0;
            r_word     <= '0;
            r_dato     <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_err      <= 1'b0;
        end else if (ENB) begin
            r_state    <= w_state_nxt;
            r_sr       <= w_rx_byte[6:0];
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_com_cnt  <= w_com_cnt_nxt;
            r_word     <= w_word_nxt;
            r_dato     <= w_dato_nxt;
            r_valid    <= w_valid_nxt;
            r_active   <= w_active_nxt;
            r_err      <= w_err_nxt;
        end else begin
            // Frozen: everything holds except the pulses, which must drop.
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign DATO   = r_dato;
    assign VALID  = r_valid;
    assign ACTIVE = r_active;
    assign ERR    = r_err;

endmodule

// File: tb/tb_s2p_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_s2p_frame_rx
//   Scoreboard bench for s2p_frame_rx. Each stimulus segment (started after a
//   reset) is built as a per-cycle list of {enable, bit}. A byte/word level
//   reference model walks the enabled bits and queues the cycles on which
//   VALID (with its word), ERR and each ACTIVE value must appear. A separate
//   monitor compares the DUT against those queues on every falling edge.
// -----------------------------------------------------------------------------
module tb_s2p_frame_rx;

    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] STP      = 8'h7C;
    localparam int         LOCK_CNT = 4;

    logic        CLK     = 1'b0;
    logic        reset   = 1'b0;
    logic        ENB     = 1'b0;
    logic        data_in = 1'b0;
    logic [31:0] DATO;
    logic        VALID;
    logic        ACTIVE;
    logic        ERR;

    s2p_frame_rx #(
        .COM      (COM),
        .STP      (STP),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .ENB     (ENB),
        .data_in (data_in),
        .DATO    (DATO),
        .VALID   (VALID),
        .ACTIVE  (ACTIVE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t vq[$];   // expected VALID cycles with their word
    int  eq[$];   // expected ERR cycles
    ev_t aq[$];   // expected ACTIVE per enabled cycle

    // Stimulus of the current segment, one entry per clock cycle.
    bit s_en[$];
    bit s_bit[$];
    bit gap_en = 1'b0;

    // Model working storage: the enabled bits and the cycle each is sampled.
    bit m_bits[$];
    int m_cyc[$];
    bit m_act[];

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) begin
            s_en.push_back(1'b0);
            s_bit.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic push_bit(input bit b);
        if (gap_en && $urandom_range(0, 9) == 0) push_gap($urandom_range(1, 3));
        s_en.push_back(1'b1);
        s_bit.push_back(b);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) push_byte(w[i*8 +: 8]);
    endtask

    task automatic push_coms(input int n);
        for (int i = 0; i < n; i++) push_byte(COM);
    endtask

    function automatic logic [7:0] model_byte(input int p);
        logic [7:0] v = '0;
        for (int j = 0; j < 8; j++) v = {v[6:0], m_bits[p+j]};
        return v;
    endfunction

    // Last eight bits seen at enabled bit k; history before reset reads as 0.
    function automatic logic [7:0] window(input int k);
        logic [7:0] v = '0;
        for (int j = 7; j >= 0; j--) begin
            int idx = k - j;
            v = {v[6:0], (idx >= 0) ? m_bits[idx] : 1'b0};
        end
        return v;
    endfunction

    // Reference model: hunt bit by bit, then consume whole bytes and words.
    task automatic run_model(input int base);
        int n, k, e, phase, com;
        logic [7:0]  b;
        logic [31:0] w;
        m_bits.delete();
        m_cyc.delete();
        for (int i = 0; i < s_en.size(); i++) begin
            if (s_en[i]) begin
                m_bits.push_back(s_bit[i]);
                m_cyc.push_back(base + i);
            end
        end
        n = m_bits.size();
        m_act = new[n];
        k = 0; phase = 0; com = 0;
        while (k < n) begin
            case (phase)
                0: begin
                    if (window(k) == COM) begin
                        phase = 1;
                        com   = 1;
                    end
                    k++;
                end
                1: begin
                    if (k + 7 >= n) begin
                        k = n;
                    end else begin
                        b = model_byte(k);
                        e = k + 7;
                        k = e + 1;
                        if (b == COM) begin
                            com++;
                            if (com == LOCK_CNT) begin
                                phase    = 2;
                                m_act[e] = 1'b1;
                            end
                        end else begin
                            phase = 0;
                        end
                    end
                end
                2: begin
                    if (k + 7 >= n) begin
                        for (int j = k; j < n; j++) m_act[j] = 1'b1;
                        k = n;
                    end else begin
                        b = model_byte(k);
                        e = k + 7;
                        for (int j = k; j < e; j++) m_act[j] = 1'b1;
                        k = e + 1;
                        if (b == COM) begin
                            m_act[e] = 1'b1;
                        end else if (b == STP) begin
                            m_act[e] = 1'b1;
                            phase    = 3;
                        end else begin
                            eq.push_back(m_cyc[e]);
                            phase = 0;
                        end
                    end
                end
                default: begin
                    if (k + 31 >= n) begin
                        for (int j = k; j < n; j++) m_act[j] = 1'b1;
                        k = n;
                    end else begin
                        w = '0;
                        for (int j = 0; j < 32; j++) begin
                            w = {w[30:0], m_bits[k+j]};
                            m_act[k+j] = 1'b1;
                        end
                        vq.push_back('{m_cyc[k+31], w});
                        k     = k + 32;
                        phase = 2;
                    end
                end
            endcase
        end
        for (int j = 0; j < n; j++) aq.push_back('{m_cyc[j], 32'(m_act[j])});
    endtask

    // Inputs change 2 ns after a rising edge and are sampled on the next one.
    task automatic drive_segment();
        @(posedge CLK);
        #2;
        run_model(cyc + 1);
        for (int i = 0; i < s_en.size(); i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #2;
            end
            ENB     = s_en[i];
            data_in = s_bit[i];
        end
        @(posedge CLK);
        #2;
        ENB = 1'b0;
        s_en.delete();
        s_bit.delete();
    endtask

    // Outputs must clear the instant reset falls, with no clock edge.
    task automatic do_reset(input string tag);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_rst_valid"},  VALID,  0);
        check({tag, "_rst_active"}, ACTIVE, 0);
        check({tag, "_rst_err"},    ERR,    0);
        check({tag, "_rst_dato"},   DATO,   0);
        repeat (2) @(posedge CLK);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compares every cycle against the scoreboard queues.
    initial begin
        logic [31:0] exp_dato;
        exp_dato = '0;
        forever begin
            @(negedge CLK);
            if (!reset) exp_dato = '0;
            if (vq.size() > 0 && vq[0].cyc == cyc) begin
                check("valid_pulse", VALID, 1);
                check("dato_word",   DATO,  vq[0].val);
                exp_dato = vq[0].val;
                void'(vq.pop_front());
            end else begin
                check("valid_idle", VALID, 0);
                check("dato_hold",  DATO,  exp_dato);
            end
            if (eq.size() > 0 && eq[0] == cyc) begin
                check("err_pulse", ERR, 1);
                void'(eq.pop_front());
            end else begin
                check("err_idle", ERR, 0);
            end
            if (aq.size() > 0 && aq[0].cyc == cyc) begin
                check("active", ACTIVE, aq[0].val);
                void'(aq.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ENB   = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        reset = 1'b1;

        // Garbage bits, lock, one word, then idle.
        push_bit(1'b0); push_bit(1'b0); push_bit(1'b0);
        push_coms(4);
        push_byte(STP);
        push_word(32'h0123_4567);
        push_coms(2);
        drive_segment();
        do_reset("lock_word");

        // One COM short of lock: STP is not a header, nothing is delivered.
        push_coms(3);
        push_byte(STP);
        push_word(32'h89AB_CDEF);
        push_coms(1);
        drive_segment();
        do_reset("no_lock");

        // Back-to-back words, a frozen payload, an illegal header, and a
        // re-lock that is cut short by reset in the middle of a word.
        push_coms(4);
        push_byte(STP); push_word(32'h092B_4D6F);
        push_byte(STP); push_word(32'hFEDC_BA98);
        push_coms(1);
        push_byte(STP);
        push_byte(8'h76); push_byte(8'h54);
        push_gap(5);
        push_byte(8'h32); push_byte(8'h10);
        push_coms(1);
        push_byte(8'h55);
        push_byte(STP); push_word(32'h1357_2468);
        push_coms(4);
        push_byte(STP); push_byte(8'hA5); push_byte(8'h5A);
        drive_segment();
        do_reset("mid_payload");

        // After reset a header without a fresh lock sequence delivers nothing.
        push_byte(STP); push_word(32'hCAFE_F00D);
        push_coms(4);
        push_byte(STP); push_word(32'hDEAD_BEEF);
        drive_segment();
        do_reset("relock");

        // Randomized segments with enable gaps and occasional bad headers.
        gap_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int nb = $urandom_range(0, 10);
            for (int i = 0; i < nb; i++) push_bit(1'($urandom_range(0, 1)));
            push_coms($urandom_range(LOCK_CNT - 1, LOCK_CNT + 1));
            for (int u = 0; u < $urandom_range(3, 6); u++) begin
                int sel = $urandom_range(0, 19);
                if (sel < 14) begin
                    push_byte(STP);
                    push_word($urandom());
                end else if (sel < 17) begin
                    push_byte(COM);
                end else begin
                    push_byte(8'($urandom_range(0, 255)));
                end
            end
            if (r % 2 == 1) begin
                push_byte(STP);
                push_byte(8'($urandom_range(0, 255)));
            end
            drive_segment();
            do_reset("random");
        end

        repeat (3) @(posedge CLK);
        check("valid_queue_drained",  vq.size(), 0);
        check("err_queue_drained",    eq.size(), 0);
        check("active_queue_drained", aq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s2p_frame_rx.md
S2P_FRAME_RX -- requirements
Module: s2p_frame_rx

Interface
REQ-001 Parameters SHALL be: COM, 8'hBC, idle/alignment byte.
REQ-002 Parameters SHALL be: STP, 8'h7C, start-of-word header byte.
REQ-003 Parameters SHALL be: LOCK_CNT, 4, consecutive aligned COM bytes required for lock (range 2..7).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  sole clock; all state on posedge CLK.
REQ-006 reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-007 ENB  input  1  enable; 0 = serial bit ignored and all state held.
REQ-008 data_in  input  1  serial bit, MSB-first per byte, sampled on posedge CLK when ENB=1.
REQ-009 DATO  output  32  last received payload word; first payload byte in [31:24].
REQ-010 VALID  output  1  one-cycle pulse, DATO updated.
REQ-011 ACTIVE  output  1  high while byte-locked (states LOCKED, DATA).
REQ-012 ERR  output  1  one-cycle pulse on loss of lock due to an illegal header byte.

Function
REQ-013 On each enabled edge, rx_byte = {sr[6:0], data_in} and sr SHALL load rx_byte; a byte is complete when bit_cnt==7 (bit_cnt 3-bit, wraps 7->0).
REQ-014 States SHALL be SEARCH, SYNC, LOCKED, DATA, registered, all outputs registered.
REQ-015 SEARCH: on every enabled edge, rx_byte==COM -> SYNC, bit_cnt=0, com_cnt=1; otherwise stay and bit_cnt is don't-care.
REQ-016 SYNC: on byte complete, rx_byte==COM -> com_cnt+1, and when com_cnt+1==LOCK_CNT -> LOCKED; rx_byte!=COM -> SEARCH, com_cnt=0, no ERR.
REQ-017 LOCKED: on byte complete, COM -> stay; STP -> DATA, byte_cnt=0; any other value -> SEARCH, ERR=1 for one cycle.
REQ-018 DATA: on byte complete, rx_byte SHALL be shifted into the word register (byte_cnt 0 -> [31:24] ... 3 -> [7:0]); COM/STP values are treated as payload.
REQ-019 On completion of byte_cnt==3, DATO SHALL load the full word and VALID SHALL be 1 for exactly the next cycle; the state SHALL return to LOCKED.
REQ-020 Latency: VALID/DATO SHALL be visible immediately after the edge sampling the 32nd payload bit.
REQ-021 DATO SHALL hold its value between VALID pulses.
REQ-022 Back-to-back words (STP immediately after payload) SHALL produce VALID pulses exactly 40 enabled cycles apart.
REQ-023 ENB=0 SHALL freeze sr, counters, state and DATO; VALID and ERR SHALL be 0 while ENB=0.
REQ-024 ACTIVE SHALL be 1 exactly when the state is LOCKED or DATA.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force state=SEARCH, sr=0, bit_cnt=0, byte_cnt=0, com_cnt=0, DATO=0, VALID=0, ACTIVE=0, ERR=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release, lock SHALL require a full LOCK_CNT COM sequence.
REQ-027 Release of reset SHALL take effect on the first posedge CLK with reset=1.

Verification
REQ-028 Reset low mid-payload -> all outputs 0 without a clock edge; after release, no VALID until re-lock.
REQ-029 3 garbage bits, 4xCOM, STP, 0x01234567 -> ACTIVE rises after the 32nd COM bit; one VALID pulse, DATO=0x01234567.
REQ-030 3xCOM then STP, 0x89ABCDEF -> ACTIVE stays 0, no VALID.
REQ-031 Locked, then STP+0x092B4D6F, STP+0xFEDCBA98 back-to-back -> two VALID pulses 40 cycles apart, DATO matches each word.
REQ-032 Locked, header byte 0x55 -> ERR one-cycle pulse, ACTIVE=0; a following STP+word produces no VALID.
REQ-033 ENB=0 for 5 cycles during payload of 0x76543210 -> DATO=0x76543210, VALID delayed by exactly 5 cycles.
